ps2_host_ctrl: RTL and testbench

Host-side command controller for the PS/2 keyboard port. It accepts one command byte with an optional argument byte from the system side, such as 0xED set-LEDs plus its LED mask. It drives the PS/2 lines through open-drain enables using the host-to-device protocol, then waits for the device's ACK/RESEND reply on the existing receive path. It gates the receiver (`rx_en`) so the receiver never decodes the host's own transmission.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_sync_edge.sv | 31 +++
 rtl/ps2_host_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ps2_host_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side command path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        TX_BITS,
        ACK,
        WAIT_RESP,
        DONE
    } state_t;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_NACK     = 2'd1;
    localparam logic [1:0] ST_TIMEOUT  = 2'd2;
    localparam logic [1:0] ST_LINE_ERR = 2'd3;

    localparam logic [7:0] PS2_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RESEND  = 8'hFE;
    localparam logic [7:0] PS2_SET_LED = 8'hED;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock and data pins, plus a falling-edge
// pulse on the synchronized clock. Idle lines are high, so the flops reset to 1.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_in,
    input  logic data_in,
    output logic data_s,
    output logic fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], clk_in};
            data_ff  <= {data_ff[0], data_in};
            clk_prev <= clk_ff[1];
        end
    end

    assign data_s = data_ff[1];
    assign fall   = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_ctrl.sv
// Host-to-device PS/2 command sender: inhibit, request-to-send, clock out one
// or two bytes, then wait for the device's ACK/RESEND on the receive path.
module ps2_host_ctrl
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 20,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic [7:0] cmd_arg,
    input  logic       cmd_has_arg,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       rx_en,
    output logic       busy,
    output logic       done,
    output logic [1:0] status
);

    localparam int INH_RAW     = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int INHIBIT_CYC = (INH_RAW < 1) ? 1 : INH_RAW;
    localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int IW          = $clog2(INHIBIT_CYC + 1);
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);
    localparam int RW          = $clog2(MAX_RETRY + 2);

    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYC);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    state_t        state, state_nxt;
    logic [1:0]    status_q, status_nxt;
    logic [7:0]    cmd_q, arg_q, tx_byte;
    logic          has_arg_q, second_q;
    logic [RW-1:0] retry_q;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] wdog;
    logic [3:0]    fall_cnt;
    logic          data_q;
    logic          data_s, fall, expired;

    ps2_sync_edge u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_in  (ps2_clk_in),
        .data_in (ps2_data_in),
        .data_s  (data_s),
        .fall    (fall)
    );

    assign tx_byte = second_q ? arg_q : cmd_q;
    assign status  = status_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        status_nxt = status_q;
        expired    = (wdog == '0);
        case (state)
            IDLE:    if (cmd_valid) state_nxt = INHIBIT;
            INHIBIT: begin
                if (expired) begin
                    state_nxt  = DONE;
                    status_nxt = ST_TIMEOUT;
                end else if (inh_cnt == INH_LAST) begin
                    state_nxt = RTS;
                end
            end
            RTS:     state_nxt = TX_BITS;
            TX_BITS: begin
                if (expired) begin
                    state_nxt  = DONE;
                    status_nxt = ST_TIMEOUT;
                end else if (fall && fall_cnt == 4'd9) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (expired) begin
                    state_nxt  = DONE;
                    status_nxt = ST_TIMEOUT;
                end else if (fall) begin
                    if (data_s) begin
                        state_nxt  = DONE;
                        status_nxt = ST_LINE_ERR;
                    end else begin
                        state_nxt = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                // A reply in the expiry cycle still counts.
                if (rx_valid) begin
                    if (rx_byte == PS2_ACK) begin
                        if (!second_q && has_arg_q) begin
                            state_nxt = INHIBIT;
                        end else begin
                            state_nxt  = DONE;
                            status_nxt = ST_OK;
                        end
                    end else if (rx_byte == PS2_RESEND) begin
                        if (retry_q < RETRY_MAX) begin
                            state_nxt = INHIBIT;
                        end else begin
                            state_nxt  = DONE;
                            status_nxt = ST_NACK;
                        end
                    end
                end else if (expired) begin
                    state_nxt  = DONE;
                    status_nxt = ST_TIMEOUT;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        cmd_ready   = (state == IDLE);
        busy        = (state != IDLE);
        done        = (state == DONE);
        ps2_clk_oe  = (state == INHIBIT);
        ps2_data_oe = data_q && (state == RTS || state == TX_BITS);
        rx_en       = !(state inside {INHIBIT, RTS, TX_BITS, ACK});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            arg_q     <= '0;
            has_arg_q <= 1'b0;
            second_q  <= 1'b0;
            retry_q   <= '0;
            inh_cnt   <= '0;
            wdog      <= '0;
            fall_cnt  <= '0;
            data_q    <= 1'b0;
            status_q  <= ST_OK;
        end else begin
            if (state == IDLE && cmd_valid) begin
                cmd_q     <= cmd_byte;
                arg_q     <= cmd_arg;
                has_arg_q <= cmd_has_arg;
                second_q  <= 1'b0;
                retry_q   <= '0;
            end
            if (state == WAIT_RESP && state_nxt == INHIBIT) begin
                if (rx_byte == PS2_ACK) begin
                    second_q <= 1'b1;
                    retry_q  <= '0;
                end else begin
                    retry_q <= retry_q + 1'b1;
                end
            end

            inh_cnt <= (state == INHIBIT) ? inh_cnt + 1'b1 : '0;

            if ((state_nxt == INHIBIT && state != INHIBIT) ||
                (state_nxt == WAIT_RESP && state != WAIT_RESP))
                wdog <= TO_LOAD;
            else if (state != IDLE && wdog != '0)
                wdog <= wdog - 1'b1;

            // data_q is the start bit (pulled low) from RTS onward, then each fall
            // shifts in the next wire bit; fall 10 releases for the stop bit.
            if (state_nxt == RTS) begin
                data_q   <= 1'b1;
                fall_cnt <= '0;
            end else if (state == TX_BITS) begin
                if (fall) begin
                    fall_cnt <= fall_cnt + 1'b1;
                    if (fall_cnt < 4'd8)       data_q <= ~tx_byte[fall_cnt[2:0]];
                    else if (fall_cnt == 4'd8) data_q <= ~odd_parity(tx_byte);
                    else                       data_q <= 1'b0;
                end
            end else if (state != RTS) begin
                data_q <= 1'b0;
            end

            if (state_nxt == DONE) status_q <= status_nxt;
        end
    end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl with a simple open-drain PS/2 device model.
module tb_ps2_host_ctrl;
    import ps2_pkg::*;

    localparam int CLK_HZ      = 1_000_000;
    localparam int INHIBIT_US  = 5;
    localparam int TIMEOUT_MS  = 1;
    localparam int MAX_RETRY   = 3;
    localparam int TIMEOUT_CYC = 1000;
    localparam int H           = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_has_arg = 1'b0;
    logic [7:0] cmd_byte = 8'h00, cmd_arg = 8'h00, rx_byte = 8'h00;
    logic       rx_valid = 1'b0, rx_en, busy, done;
    logic [1:0] status;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;

    int         vectors = 0, miscompares = 0;
    int         done_cnt = 0;
    logic [1:0] last_status = 2'd0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_ctrl #(
        .CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_MS(TIMEOUT_MS), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_byte(cmd_byte), .cmd_arg(cmd_arg), .cmd_has_arg(cmd_has_arg),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_en(rx_en),
        .busy(busy), .done(done), .status(status)
    );

    always @(negedge clk) begin
        if (done) begin
            done_cnt    <= done_cnt + 1;
            last_status <= status;
        end
    end

    task automatic issue(input logic [7:0] c, input logic [7:0] a, input logic h);
        @(negedge clk);
        cmd_byte = c; cmd_arg = a; cmd_has_arg = h; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic respond(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Device side: wait for RTS, clock nfalls pulses, sample the wire while clk is low.
    task automatic dev_frame(input int nfalls, input bit ack_low, output logic [7:0] data,
                             output logic par, output logic stop, output logic rxen_bad,
                             output logic seen);
        int cnt = 0;
        data = '0; par = 1'b0; stop = 1'b0; rxen_bad = 1'b0; seen = 1'b0;
        while (!(ps2_data_oe && !ps2_clk_oe) && cnt < 200) begin
            @(negedge clk); cnt++;
        end
        if (cnt >= 200) return;
        seen = 1'b1;
        for (int i = 1; i <= nfalls; i++) begin
            if (i == 11) dev_data_low = ack_low;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            if (i <= 10 && rx_en) rxen_bad = 1'b1;
            if (i <= 8)       data[i-1] = ps2_data_in;
            else if (i == 9)  par = ps2_data_in;
            else if (i == 10) stop = ps2_data_in;
            dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic wait_done(input int ref_cnt, output logic ok);
        int cnt = 0;
        while (done_cnt == ref_cnt && cnt < 3000) begin
            @(negedge clk); cnt++;
        end
        ok = (done_cnt != ref_cnt);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if (ps2_clk_oe !== 1'b0) begin miscompares++; $display("FAIL reset clk_oe: got %b want 0", ps2_clk_oe); end
        vectors++; if (ps2_data_oe !== 1'b0) begin miscompares++; $display("FAIL reset data_oe: got %b want 0", ps2_data_oe); end
        vectors++; if (rx_en !== 1'b1) begin miscompares++; $display("FAIL reset rx_en: got %b want 1", rx_en); end
        vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL reset busy/done: got %b want 00", {busy, done}); end
        vectors++; if (status !== 2'd0) begin miscompares++; $display("FAIL reset status: got %0d want 0", status); end
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset cmd_ready: got %b want 1", cmd_ready); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_set_led();
        logic [7:0] b; logic p, s, bad, seen, ok; int ref_cnt;
        ref_cnt = done_cnt;
        issue(PS2_SET_LED, 8'h02, 1'b1);
        dev_frame(11, 1'b1, b, p, s, bad, seen);
        vectors++; if (seen !== 1'b1 || b !== 8'hED) begin miscompares++; $display("FAIL set_led byte0: got %h want ed", b); end
        vectors++; if (p !== 1'b1 || s !== 1'b1) begin miscompares++; $display("FAIL set_led par0/stop: got %b%b want 11", p, s); end
        vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL set_led rx_en0: got high want low"); end
        vectors++; if (rx_en !== 1'b1) begin miscompares++; $display("FAIL set_led rx_en wait: got %b want 1", rx_en); end
        respond(PS2_ACK);
        dev_frame(11, 1'b1, b, p, s, bad, seen);
        vectors++; if (seen !== 1'b1 || b !== 8'h02) begin miscompares++; $display("FAIL set_led byte1: got %h want 02", b); end
        vectors++; if (p !== 1'b0 || s !== 1'b1) begin miscompares++; $display("FAIL set_led par1/stop: got %b%b want 01", p, s); end
        vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL set_led rx_en1: got high want low"); end
        respond(PS2_ACK);
        wait_done(ref_cnt, ok);
        vectors++; if (ok !== 1'b1 || last_status !== ST_OK) begin miscompares++; $display("FAIL set_led status: got %0d (done %b) want 0", last_status, ok); end
    endtask

    task automatic test_resend();
        logic [7:0] b; logic p, s, bad, seen, ok; int ref_cnt;
        ref_cnt = done_cnt;
        issue(PS2_SET_LED, 8'h00, 1'b0);
        dev_frame(11, 1'b1, b, p, s, bad, seen);
        respond(PS2_RESEND);
        dev_frame(11, 1'b1, b, p, s, bad, seen);
        vectors++; if (seen !== 1'b1 || b !== 8'hED) begin miscompares++; $display("FAIL resend byte: got %h want ed", b); end
        respond(PS2_ACK);
        wait_done(ref_cnt, ok);
        vectors++; if (ok !== 1'b1 || last_status !== ST_OK) begin miscompares++; $display("FAIL resend status: got %0d (done %b) want 0", last_status, ok); end
    endtask

    task automatic test_nack();
        logic [7:0] b; logic p, s, bad, seen, ok; int ref_cnt, frames;
        ref_cnt = done_cnt; frames = 0;
        issue(PS2_SET_LED, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            dev_frame(11, 1'b1, b, p, s, bad, seen);
            if (seen && b == 8'hED) frames++;
            vectors++; if (done_cnt !== ref_cnt) begin miscompares++; $display("FAIL nack early done: got %0d want %0d", done_cnt, ref_cnt); end
            respond(PS2_RESEND);
        end
        wait_done(ref_cnt, ok);
        vectors++; if (frames !== 4) begin miscompares++; $display("FAIL nack frames: got %0d want 4", frames); end
        vectors++; if (ok !== 1'b1 || last_status !== ST_NACK) begin miscompares++; $display("FAIL nack status: got %0d (done %b) want 1", last_status, ok); end
    endtask

    task automatic test_timeout();
        int cyc = 0;
        @(negedge clk);
        cmd_byte = 8'hF4; cmd_has_arg = 1'b0; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        while (!done && cyc < TIMEOUT_CYC + 100) begin
            @(posedge clk); #1; cyc++;
        end
        vectors++; if (cyc !== TIMEOUT_CYC + 1) begin miscompares++; $display("FAIL timeout latency: got %0d want %0d", cyc, TIMEOUT_CYC + 1); end
        vectors++; if (status !== ST_TIMEOUT) begin miscompares++; $display("FAIL timeout status: got %0d want 2", status); end
        vectors++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin miscompares++; $display("FAIL timeout oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
        @(negedge clk);
    endtask

    task automatic test_line_err();
        logic [7:0] b; logic p, s, bad, seen, ok; int ref_cnt;
        ref_cnt = done_cnt;
        issue(PS2_SET_LED, 8'h00, 1'b0);
        dev_frame(11, 1'b0, b, p, s, bad, seen);
        wait_done(ref_cnt, ok);
        vectors++; if (ok !== 1'b1 || last_status !== ST_LINE_ERR) begin miscompares++; $display("FAIL line_err status: got %0d (done %b) want 3", last_status, ok); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b; logic p, s, bad, seen; int ref_cnt;
        issue(8'hF0, 8'h00, 1'b0);
        dev_frame(4, 1'b1, b, p, s, bad, seen);
        vectors++; if (ps2_data_oe !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL midrst pre: got oe %b busy %b want 1 1", ps2_data_oe, busy); end
        ref_cnt = done_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin miscompares++; $display("FAIL midrst oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
        vectors++; if ({rx_en, cmd_ready, busy, done} !== 4'b1100) begin miscompares++; $display("FAIL midrst ctl: got %b want 1100", {rx_en, cmd_ready, busy, done}); end
        vectors++; if (status !== 2'd0) begin miscompares++; $display("FAIL midrst status: got %0d want 0", status); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        vectors++; if (done_cnt !== ref_cnt) begin miscompares++; $display("FAIL midrst done: got %0d want %0d", done_cnt, ref_cnt); end
    endtask

    task automatic test_stray_byte();
        logic [7:0] b; logic p, s, bad, seen, ok; int ref_cnt, starts;
        ref_cnt = done_cnt; starts = 0;
        issue(PS2_SET_LED, 8'h00, 1'b0);
        dev_frame(11, 1'b1, b, p, s, bad, seen);
        respond(8'h1C);
        repeat (5) @(negedge clk);
        vectors++; if (busy !== 1'b1 || done_cnt !== ref_cnt) begin miscompares++; $display("FAIL stray ignored: got busy %b dones %0d want 1 %0d", busy, done_cnt, ref_cnt); end
        cmd_byte = 8'hAA; cmd_valid = 1'b1;
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL stray cmd_ready: got %b want 0", cmd_ready); end
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        respond(PS2_ACK);
        wait_done(ref_cnt, ok);
        vectors++; if (ok !== 1'b1 || last_status !== ST_OK) begin miscompares++; $display("FAIL stray status: got %0d (done %b) want 0", last_status, ok); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ps2_clk_oe || busy) starts++;
        end
        vectors++; if (starts !== 0) begin miscompares++; $display("FAIL stray queued cmd: got %0d busy cycles want 0", starts); end
    endtask

    initial begin
        test_reset();
        test_set_led();
        test_resend();
        test_nack();
        test_timeout();
        test_line_err();
        test_reset_mid_frame();
        test_stray_byte();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global time limit: simulation did not complete");
        $fatal(1);
    end

endmodule
